// File: rtl/reg_write_queue.sv
// Register write queue: buffers register-file writes and drains one per cycle into RegWre/WriteReg/WriteData.
// Define WB_BYPASS_EN to enable the rs/rt lookup over queued-but-uncommitted writes.
module reg_write_queue #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic                       CLK,
   input  logic                       Reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_W-1:0]          in_addr,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       wb_hold,
   input  logic                       flush,
   output logic                       RegWre,
   output logic [ADDR_W-1:0]          WriteReg,
   output logic [DATA_W-1:0]          WriteData,
   output logic [$clog2(DEPTH+1)-1:0] count,
   input  logic [ADDR_W-1:0]          rs,
   input  logic [ADDR_W-1:0]          rt,
   output logic                       byp_hit1,
   output logic                       byp_hit2,
   output logic [DATA_W-1:0]          byp_data1,
   output logic [DATA_W-1:0]          byp_data2
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] addrMem [DEPTH];
   logic [DATA_W-1:0] dataMem [DEPTH];
   logic [PTR_W-1:0]  headPtr;
   logic [PTR_W-1:0]  tailPtr;
   logic              isEmpty;
   logic              isFull;
   logic              pushEn;

   assign isEmpty   = (count == '0);
   assign isFull    = (count == CNT_W'(DEPTH));
   assign in_ready  = !isFull;
   assign RegWre    = !isEmpty && !wb_hold && !flush;
   assign WriteReg  = isEmpty ? '0 : addrMem[headPtr];
   assign WriteData = isEmpty ? '0 : dataMem[headPtr];

   // Writes to register 0 complete the handshake but are dropped here.
   assign pushEn = in_valid && !isFull && !flush && (in_addr != '0);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
      end else if (flush) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
      end else begin
         if (pushEn) tailPtr <= tailPtr + PTR_W'(1);
         if (RegWre) headPtr <= headPtr + PTR_W'(1);
         count <= count + CNT_W'(pushEn) - CNT_W'(RegWre);
      end
   end

   // NOTE: entry storage has no reset; count gates every read, so stale contents are never visible.
   always_ff @(posedge CLK) begin
      if (pushEn) begin
         addrMem[tailPtr] <= in_addr;
         dataMem[tailPtr] <= in_data;
      end
   end

`ifdef WB_BYPASS_EN
   logic [PTR_W-1:0] scanIdx;

   // Scan oldest to youngest so the last match (nearest tail) wins.
   // NOTE: every output of this block gets a default first, so no latches are inferred.
   always_comb begin
      byp_hit1  = 1'b0;
      byp_hit2  = 1'b0;
      byp_data1 = '0;
      byp_data2 = '0;
      scanIdx   = headPtr;
      for (int i = 0; i < DEPTH; i++) begin
         scanIdx = headPtr + PTR_W'(i);
         if (CNT_W'(i) < count) begin
            if (rs != '0 && addrMem[scanIdx] == rs) begin
               byp_hit1  = 1'b1;
               byp_data1 = dataMem[scanIdx];
            end
            if (rt != '0 && addrMem[scanIdx] == rt) begin
               byp_hit2  = 1'b1;
               byp_data2 = dataMem[scanIdx];
            end
         end
      end
   end
`else
   logic unusedBypassAddr;

   assign unusedBypassAddr = ^{rs, rt};
   assign byp_hit1  = 1'b0;
   assign byp_hit2  = 1'b0;
   assign byp_data1 = '0;
   assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_reg_write_queue.sv
// Scoreboard bench for reg_write_queue: a queue-based reference model predicts commits, count,
// in_ready and bypass; a negedge monitor compares whatever the DUT presents.
module tb_reg_write_queue;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH+1);
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_t;

   logic              CLK = 1'b0;
   logic              Reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [ADDR_W-1:0] in_addr = '0;
   logic [DATA_W-1:0] in_data = '0;
   logic              wb_hold = 1'b0;
   logic              flush = 1'b0;
   logic              RegWre;
   logic [ADDR_W-1:0] WriteReg;
   logic [DATA_W-1:0] WriteData;
   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] rs = '0;
   logic [ADDR_W-1:0] rt = '0;
   logic              byp_hit1, byp_hit2;
   logic [DATA_W-1:0] byp_data1, byp_data2;

   req_t modelQ[$];   // entries the queue should hold right now
   req_t expQ[$];     // scoreboard: commits still expected on the write port
   int   nCompared   = 0;
   int   nMismatched = 0;

   reg_write_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .wb_hold(wb_hold), .flush(flush),
      .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData), .count(count),
      .rs(rs), .rt(rt), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
      .byp_data1(byp_data1), .byp_data2(byp_data2)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Youngest queued value for a register; register 0 never hits.
   function automatic void bypassRef(input logic [ADDR_W-1:0] a, output logic hit,
                                     output logic [DATA_W-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (BYP && a != '0)
         foreach (modelQ[i])
            if (modelQ[i].addr == a) begin
               hit = 1'b1;
               d   = modelQ[i].data;
            end
   endfunction

   // Apply one clock edge to the model using the inputs held across it.
   task automatic tick();
      bit doPop, wasFull;
      @(posedge CLK);
      doPop   = modelQ.size() > 0 && !wb_hold && !flush;
      wasFull = modelQ.size() == DEPTH;
      if (flush) begin
         modelQ.delete();
         expQ.delete();
      end else begin
         if (doPop) void'(modelQ.pop_front());
         if (in_valid && !wasFull && in_addr != '0) begin
            modelQ.push_back('{addr: in_addr, data: in_data});
            expQ.push_back('{addr: in_addr, data: in_data});
         end
      end
      #1;
   endtask

   task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   always @(negedge CLK) begin : monitor
      logic              eh;
      logic [DATA_W-1:0] ed;
      req_t              r;
      check("RegWre", RegWre, modelQ.size() > 0 && !wb_hold && !flush);
      check("count", count, modelQ.size());
      check("in_ready", in_ready, modelQ.size() < DEPTH);
      if (modelQ.size() > 0) begin
         check("head_addr", WriteReg, modelQ[0].addr);
         check("head_data", WriteData, modelQ[0].data);
      end else begin
         check("idle_addr", WriteReg, 0);
         check("idle_data", WriteData, 0);
      end
      if (RegWre) begin
         if (expQ.size() == 0) check("commit_unexpected", RegWre, 0);
         else begin
            r = expQ.pop_front();
            check("commit_addr", WriteReg, r.addr);
            check("commit_data", WriteData, r.data);
         end
      end
      bypassRef(rs, eh, ed);
      check("byp_hit1", byp_hit1, eh);
      check("byp_data1", byp_data1, ed);
      bypassRef(rt, eh, ed);
      check("byp_hit2", byp_hit2, eh);
      check("byp_data2", byp_data2, ed);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (nCompared=%0d)", nCompared);
      $fatal(1, "watchdog");
   end

   initial begin
      #1 Reset = 1'b0;
      #10 Reset = 1'b1;

      // Single write into an empty queue: visible next cycle, gone the cycle after.
      push(4'd5, 16'h1234);
      check("single_wre", RegWre, 1);
      check("single_addr", WriteReg, 5);
      check("single_data", WriteData, 16'h1234);
      tick();
      check("single_after_wre", RegWre, 0);
      check("single_after_cnt", count, 0);

      // Held queue fills at DEPTH; the fifth request is refused.
      wb_hold = 1'b1;
      for (int i = 0; i < 5; i++) push(ADDR_W'(i + 1), DATA_W'(16'hA000 + i));
      check("full_cnt", count, DEPTH);
      check("full_ready", in_ready, 0);
      wb_hold = 1'b0;
      repeat (DEPTH + 1) tick();
      check("drained_cnt", count, 0);

      // Full queue: a pop and a push in the same cycle -> push refused, count drops by one.
      wb_hold = 1'b1;
      for (int i = 0; i < DEPTH; i++) push(ADDR_W'(i + 6), DATA_W'($urandom));
      wb_hold = 1'b0;
      push(4'd12, 16'hBEEF);
      check("simul_cnt", count, DEPTH - 1);
      repeat (DEPTH) tick();

      // Register 0 is accepted but never stored; flush drops a same-cycle push.
      push(4'd0, 16'h5555);
      check("zero_cnt", count, 0);
      wb_hold = 1'b1;
      push(4'd1, 16'h0101);
      push(4'd2, 16'h0202);
      flush = 1'b1;
      check("flush_ready", in_ready, 1);
      push(4'd3, 16'h0303);
      flush = 1'b0;
      check("flush_cnt", count, 0);
      check("flush_wre", RegWre, 0);

      // Bypass returns the youngest of two queued writes to r3.
      rs = 4'd3;
      rt = 4'd4;
      push(4'd3, 16'h0011);
      push(4'd3, 16'h0022);
      check("byp_dir_hit", byp_hit1, BYP);
      check("byp_dir_data", byp_data1, BYP ? 16'h0022 : 16'h0000);
      check("byp_dir_miss", byp_hit2, 0);

      // Asynchronous reset mid-queue takes effect without a clock edge.
      push(4'd7, 16'h0777);
      #1 Reset = 1'b0;
      modelQ.delete();
      expQ.delete();
      #1;
      check("rst_cnt", count, 0);
      check("rst_wre", RegWre, 0);
      check("rst_ready", in_ready, 1);
      check("rst_byp", byp_hit1, 0);
      Reset = 1'b1;
      wb_hold = 1'b0;
      tick();

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_addr  = ADDR_W'($urandom_range(0, 7));
         in_data  = DATA_W'($urandom);
         wb_hold  = ($urandom_range(0, 9) < 3);
         flush    = ($urandom_range(0, 29) == 0);
         rs       = ADDR_W'($urandom_range(0, 7));
         rt       = ADDR_W'($urandom_range(0, 7));
         tick();
      end
      in_valid = 1'b0;
      wb_hold  = 1'b0;
      flush    = 1'b0;
      repeat (DEPTH + 2) tick();
      check("final_cnt", count, 0);
      check("scoreboard_empty", expQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
